// File: rtl/mem_stage_if.sv
// Data-cache request/response bundle between the memory stage and the D-cache.
// Requests are a one-cycle pulse; the cache answers later with a one-cycle ack.
interface mem_stage_if;
    logic [31:0] dc_addr;
    logic [31:0] dc_wdata;
    logic        dc_we;
    logic        dc_send_pulse;
    logic [31:0] dc_rdata;
    logic        dc_ack;

    modport master (
        output dc_addr,
        output dc_wdata,
        output dc_we,
        output dc_send_pulse,
        input  dc_rdata,
        input  dc_ack
    );

    modport slave (
        input  dc_addr,
        input  dc_wdata,
        input  dc_we,
        input  dc_send_pulse,
        output dc_rdata,
        output dc_ack
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory stage: jump/branch flush, pulse/ack D-cache handshake with
// pipeline stall, MEM forwarding and the MEM/WB register.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        regwrite,
    input  logic        load,
    input  logic        store,
    input  logic        jal,
    input  logic        jalr,
    input  logic        branch_cond,
    input  logic [31:0] target,
    input  logic [31:0] result,
    input  logic [31:0] store_data,
    input  logic [4:0]  regD,
    output logic        stall,
    output logic        jal_flush,
    output logic [31:0] j_target,
    output logic        branch_flush,
    output logic [31:0] b_target,
    mem_stage_if.master dc,
    output logic        regwrite_mem,
    output logic [4:0]  regD_mem,
    output logic [31:0] regD_val_mem,
    output logic        regwrite_wb,
    output logic [4:0]  regD_wb,
    output logic [31:0] regD_val_wb
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [31:0] ld_buf_reg;
    logic        mem_op;
    logic        in_req;
    logic        rd_nonzero;

    assign mem_op     = load | store;
    assign in_req     = (state_reg == ST_REQ);
    assign rd_nonzero = (regD != 5'd0);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (mem_op) state_next = ST_REQ;
            ST_REQ:  state_next = ST_WAIT;
            ST_WAIT: if (dc.dc_ack) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Ack is only meaningful while waiting; stray acks elsewhere are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            ld_buf_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_WAIT && dc.dc_ack) begin
                ld_buf_reg <= dc.dc_rdata;
            end
        end
    end

    // DONE releases the stall so the op can retire on the edge that ends it.
    assign stall = mem_op && (state_reg != ST_DONE);

    assign dc.dc_send_pulse = in_req;
    assign dc.dc_we         = in_req & store;
    assign dc.dc_addr       = in_req ? {result[31:2], 2'b00} : 32'd0;
    assign dc.dc_wdata      = in_req ? store_data : 32'd0;

    assign jal_flush    = jal | jalr;
    assign j_target     = jal_flush ? target : 32'd0;
    assign branch_flush = branch_cond;
    assign b_target     = branch_cond ? target : 32'd0;

    // Load data does not exist yet in MEM, so loads never forward from here.
    assign regwrite_mem = regwrite && !load && rd_nonzero;
    assign regD_mem     = regD;
    assign regD_val_mem = result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_wb <= 1'b0;
            regD_wb     <= 5'd0;
            regD_val_wb <= 32'd0;
        end else if (stall) begin
            regwrite_wb <= 1'b0;
        end else begin
            regwrite_wb <= regwrite && rd_nonzero;
            regD_wb     <= regD;
            regD_val_wb <= load ? ld_buf_reg : result;
        end
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage RV32I pipeline. It sits directly downstream of `execute` and consumes its EX/MEM outputs. It resolves jumps and taken branches into flush requests for fetch/decode/execute. It runs a pulse/ack handshake with the data cache for `lw`/`sw`, stalling the pipeline while the access is outstanding. It also registers the MEM/WB result and drives both forwarding paths back into `execute`.

## Interface
Parameters: none (32-bit datapath, word accesses only).

Ports:
- `clk` in 1: pipeline clock, rising-edge.
- `rst` in 1: reset. Asynchronous and active-high.
- `regwrite` in 1: instruction writes rd (from execute `regwrite`).
- `load`, `store`, `jal`, `jalr`, `branch_cond` in 1 each: from execute `loadF`, `storeF`, `jalF`, `jalrF`, `branch_cond`.
- `target` in 32: jump/branch destination.
- `result` in 32: ALU result. Holds the memory address for `lw`/`sw` and the link value (pc+4) for `jal`/`jalr`.
- `store_data` in 32: `sw` data.
- `regD` in 5: destination register (execute `regDF`).
- `stall` out 1: freezes fetch/decode/execute.
- `jal_flush` out 1, `j_target` out 32: jump redirect.
- `branch_flush` out 1, `b_target` out 32: taken-branch redirect.
- `dc_addr` out 32, `dc_wdata` out 32, `dc_we` out 1, `dc_send_pulse` out 1: data-cache request.
- `dc_rdata` in 32, `dc_ack` in 1: data-cache response.
- `regwrite_mem` out 1, `regD_mem` out 5, `regD_val_mem` out 32: MEM forwarding.
- `regwrite_wb` out 1, `regD_wb` out 5, `regD_val_wb` out 32: MEM/WB register. This feeds the regfile write port and WB forwarding.

## Operation
- FSM states:
  - IDLE: if `load|store`, go to REQ; otherwise stay.
  - REQ: `dc_send_pulse`=1; go to WAIT.
  - WAIT: on `dc_ack`=1, capture `dc_rdata` into `ld_buf` and go to DONE; otherwise stay.
  - DONE: go to IDLE.
- `dc_ack` is honoured only in WAIT. It is ignored in IDLE, REQ and DONE.
- `stall` = (`load|store`) && state != DONE. Combinational, so it is high in the same cycle a memory op first appears.
- Cache request signals:
  - `dc_addr` = {`result[31:2]`, 2'b00}.
  - `dc_wdata` = `store_data`.
  - `dc_we` = `store` && state==REQ.
  - All request signals are 0 outside REQ.
  - The inputs are held stable by the stall, so the request is stable throughout REQ/WAIT.
- `jal_flush` = `jal|jalr`, with `j_target` = `target`.
- `branch_flush` = `branch_cond`, with `b_target` = `target`.
- Both flush outputs are combinational and valid in the cycle the instruction is in MEM. Targets are 0 when the corresponding flush is low.
- MEM forwarding:
  - `regD_mem` = `regD`.
  - `regD_val_mem` = `result`.
  - `regwrite_mem` = `regwrite` && !`load` && `regD`!=0. Load data is never forwarded from MEM.
- MEM/WB register, on each rising edge:
  - If `stall`=0, load `regwrite_wb` = `regwrite` && `regD`!=0, `regD_wb` = `regD`, and `regD_val_wb` = (`load` ? `ld_buf` : `result`).
  - If `stall`=1, load a bubble: `regwrite_wb`=0; other fields hold.
- A store has `regwrite`=0 and produces no writeback.

## Timing
- Reset: state=IDLE, `ld_buf`=0, all WB outputs 0. `dc_send_pulse`, `dc_we`, `dc_addr` and `dc_wdata` are 0 while `rst`=1. Flush outputs are combinational and follow the inputs.
- Memory op timeline (op arrives in cycle 0):
  - cycle 0: IDLE, `stall`=1.
  - cycle 1: REQ, single-cycle pulse.
  - cycle 2 onward: WAIT.
  - cycle after ack: DONE, `stall`=0.
  - The WB register captures the op on the edge ending DONE.
- Minimum MEM occupancy is 4 cycles (ack in cycle 2). Longer ack latency stretches WAIT with `stall` held high.
- Exactly one `dc_send_pulse` per memory op.
- Non-memory ops: `stall`=0 and 1-cycle MEM occupancy. Flush lasts exactly the one cycle the jump or taken branch is in MEM.
- Back-to-back memory ops: DONE then IDLE. The next op's `stall` rises in its cycle 0, with no spurious DONE carry-over.
- `rst` mid-access: FSM returns to IDLE immediately and the pulse is dropped. A late ack is ignored. `stall` re-asserts after reset only if a new op is presented.
- A load to x0 completes the full handshake but writes nothing.

## Test plan
- `lw` with `result`=0x24, `regD`=18; ack 3 cycles after pulse with `dc_rdata`=0xDEADBEEF.
  - Expect: `stall` high for 5 cycles, one pulse, `dc_addr`=0x24, `dc_we`=0.
  - Expect: `regD_wb`=18, `regD_val_wb`=0xDEADBEEF, `regwrite_wb`=1 for one cycle.
  - Expect: `regwrite_mem`=0 throughout.
- `sw` with `result`=0x1E, `store_data`=0x100; ack in cycle 2.
  - Expect: `dc_addr`=0x1C, `dc_wdata`=0x100, `dc_we`=1 only in REQ, `stall` 0 in cycle 3, `regwrite_wb`=0.
- `add` with `regD`=5, `result`=0x110.
  - Expect: `regwrite_mem`=1, `regD_val_mem`=0x110 in the same cycle, then `regD_val_wb`=0x110 next cycle, `stall`=0.
- `jal` with `target`=84, `result`=0x44, `regD`=8.
  - Expect: `jal_flush`=1, `j_target`=84 for one cycle, and `regD_val_wb`=0x44 next cycle.
- `branch_cond`=1 with `target`=0x18.
  - Expect: `branch_flush`=1, `b_target`=0x18 for one cycle, and `regwrite_wb`=0.
- Assert `rst` during WAIT of a `lw`, then ack.
  - Expect: state IDLE, no writeback, WB outputs 0.
  - Expect: a later `lw` produces exactly one new pulse.
